// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, waits out ROM latency, latches the opcode
// into the IR and hands it to execute. Optional breakpoint logic under FETCH_BREAKPOINT_EN.
module fetch_unit #(
  parameter int          ROM_LAT = 1,
  parameter logic [7:0]  HALT_OP = 8'hFF,
  parameter int          PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        edit,
  output logic [7:0]  address,
  input  logic [31:0] opcode,
  output logic [7:0]  ir_op,
  output logic [7:0]  ir_a,
  output logic [7:0]  ir_b,
  output logic [7:0]  ir_dst,
  output logic        ir_valid,
  input  logic        done,
  input  logic        jump,
  input  logic [7:0]  jump_target,
`ifdef FETCH_BREAKPOINT_EN
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  output logic        bp_hit,
`endif
  output logic        halted,
  output logic [7:0]  pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] LAT  = 2'(ROM_LAT);
  localparam logic [7:0] STEP = 8'(PC_STEP);

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [7:0]  ir_reg [4];
  logic        ir_load;
  logic [7:0]  retire_pc;

`ifdef FETCH_BREAKPOINT_EN
  // armed: breakpoint may fire; resume: parked on a hit, waiting for a run rising edge
  logic        bp_armed_reg, bp_armed_next;
  logic        bp_resume_reg, bp_resume_next;
  logic        bp_hit_reg, bp_hit_next;
  logic        run_q_reg;
`endif

  assign retire_pc = jump ? jump_target : pc_reg + STEP;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    ir_load    = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
    bp_armed_next  = bp_armed_reg;
    bp_resume_next = bp_resume_reg;
    bp_hit_next    = 1'b0;
`endif
    if (edit) begin
      state_next = IDLE;
      pc_next    = 8'h00;
      cnt_next   = 2'd0;
`ifdef FETCH_BREAKPOINT_EN
      bp_armed_next  = 1'b1;
      bp_resume_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
`ifdef FETCH_BREAKPOINT_EN
          if (bp_resume_reg) begin
            if (run && !run_q_reg) begin
              state_next     = FETCH;
              cnt_next       = 2'd0;
              bp_resume_next = 1'b0;
            end
          end else if (run) begin
            if (bp_en && bp_armed_reg && pc_reg == bp_addr) begin
              bp_hit_next    = 1'b1;
              bp_armed_next  = 1'b0;
              bp_resume_next = 1'b1;
            end else begin
              state_next = FETCH;
              cnt_next   = 2'd0;
            end
          end
`else
          if (run) begin
            state_next = FETCH;
            cnt_next   = 2'd0;
          end
`endif
        end
        FETCH: begin
          if (cnt_reg != LAT) begin
            cnt_next = cnt_reg + 2'd1;
          end else begin
            ir_load    = 1'b1;
            state_next = (opcode[7:0] == HALT_OP) ? HALT : ISSUE;
          end
        end
        ISSUE: begin
          if (done) begin
            pc_next    = retire_pc;
            cnt_next   = 2'd0;
            state_next = run ? FETCH : IDLE;
`ifdef FETCH_BREAKPOINT_EN
            // retirement re-arms, so the next PC is checked immediately
            bp_armed_next = 1'b1;
            if (run && bp_en && retire_pc == bp_addr) begin
              state_next     = IDLE;
              bp_hit_next    = 1'b1;
              bp_armed_next  = 1'b0;
              bp_resume_next = 1'b1;
            end
`endif
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= 8'h00;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
    end
  end

  // IR only changes on the FETCH latch edge; edit leaves it intact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) ir_reg[i] <= 8'h00;
    end else if (ir_load) begin
      for (int i = 0; i < 4; i++) ir_reg[i] <= opcode[8*i +: 8];
    end
  end

`ifdef FETCH_BREAKPOINT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_armed_reg  <= 1'b1;
      bp_resume_reg <= 1'b0;
      bp_hit_reg    <= 1'b0;
      run_q_reg     <= 1'b0;
    end else begin
      bp_armed_reg  <= bp_armed_next;
      bp_resume_reg <= bp_resume_next;
      bp_hit_reg    <= bp_hit_next;
      run_q_reg     <= run;
    end
  end

  assign bp_hit = bp_hit_reg;
`endif

  assign pc       = pc_reg;
  assign address  = pc_reg;
  assign ir_op    = ir_reg[0];
  assign ir_a     = ir_reg[1];
  assign ir_b     = ir_reg[2];
  assign ir_dst   = ir_reg[3];
  assign ir_valid = (state_reg == ISSUE);
  assign halted   = (state_reg == HALT);

endmodule
